// File: rtl/fifo_push_arb_if.sv
// Push-side bundle between NUM_REQ requesters, the arbiter and the FIFO push port.
// slave = arbiter view, master = requester/FIFO-side view.
interface fifo_push_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16
);
    localparam int OW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_i;
    logic [NUM_REQ*DATA_W-1:0] req_data_i;
    logic [NUM_REQ-1:0]        req_last_i;
    logic                      fifo_full_i;
    logic [NUM_REQ-1:0]        gnt_o;
    logic                      push_o;
    logic [DATA_W-1:0]         push_data_o;
    logic [OW-1:0]             owner_o;
    logic                      busy_o;

    modport slave (
        input  req_i, req_data_i, req_last_i, fifo_full_i,
        output gnt_o, push_o, push_data_o, owner_o, busy_o
    );

    modport master (
        output req_i, req_data_i, req_last_i, fifo_full_i,
        input  gnt_o, push_o, push_data_o, owner_o, busy_o
    );
endinterface

// File: rtl/fifo_push_arb.sv
// Burst-locked round-robin arbiter sharing one FIFO push port among NUM_REQ requesters.
// Optional FIFO_PUSH_ARB_STATS_EN adds a saturating stall-cycle counter (stall_clr_i/stall_cnt_o).
module fifo_push_arb #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    fifo_push_arb_if.slave     bus
`ifdef FIFO_PUSH_ARB_STATS_EN
    ,
    input  logic               stall_clr_i,
    output logic [15:0]        stall_cnt_o
`endif
);
    localparam int          OW = $clog2(NUM_REQ);
    localparam int          CW = $clog2(MAX_BURST + 1);
    localparam int unsigned NR = NUM_REQ;
    localparam int unsigned DW = DATA_W;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [OW-1:0]       r_owner;
    logic [OW-1:0]       r_last;
    logic [CW-1:0]       r_cnt;
    logic [NUM_REQ-1:0]  r_gnt;

    logic                w_busy;
    logic                w_own_req;
    logic                w_beat;
    logic                w_release;
    logic [CW-1:0]       w_cnt_inc;
    logic [OW-1:0]       w_pick;
    logic [OW-1:0]       w_idx;
    logic                w_found;
    logic [DATA_W-1:0]   w_sel_data;

    // Round-robin search starting just after the last owner, wrapping around.
    always_comb begin
        w_pick  = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int unsigned i = 1; i <= NR; i++) begin
            w_idx = OW'((32'(r_last) + i) % NR);
            if (!w_found && bus.req_i[w_idx]) begin
                w_pick  = w_idx;
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_data = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            if (r_owner == OW'(k)) w_sel_data = bus.req_data_i[k*DW +: DW];
        end
    end

    always_comb begin
        w_busy    = (r_state == GRANT);
        w_own_req = bus.req_i[r_owner];
        w_beat    = w_busy & w_own_req & ~bus.fifo_full_i;
        w_cnt_inc = r_cnt + CW'(1);
        // last is only honoured on a transferred beat; a dropped request releases without pushing
        w_release = w_busy & (~w_own_req |
                    (w_beat & (bus.req_last_i[r_owner] | (w_cnt_inc == CW'(MAX_BURST)))));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (|bus.req_i) w_state_nxt = GRANT;
            GRANT: if (w_release)  w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.gnt_o       = r_gnt;
        bus.busy_o      = w_busy;
        bus.owner_o     = r_owner;
        bus.push_o      = w_beat;
        bus.push_data_o = w_busy ? w_sel_data : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_owner <= '0;
            r_last  <= OW'(NUM_REQ - 1);
            r_cnt   <= '0;
            r_gnt   <= '0;
        end else if (r_state == IDLE) begin
            if (|bus.req_i) begin
                r_owner <= w_pick;
                r_cnt   <= '0;
                r_gnt   <= NUM_REQ'(1) << w_pick;
            end
        end else begin
            if (w_beat) r_cnt <= w_cnt_inc;
            if (w_release) begin
                r_last <= r_owner;
                r_gnt  <= '0;
            end
        end
    end

`ifdef FIFO_PUSH_ARB_STATS_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_stall_cnt <= '0;
        else if (stall_clr_i)
            r_stall_cnt <= '0;
        else if (w_busy && w_own_req && bus.fifo_full_i && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign stall_cnt_o = r_stall_cnt;
`endif
endmodule

// File: tb/tb_fifo_push_arb.sv
// Directed bench for fifo_push_arb (NUM_REQ=4, DATA_W=16, MAX_BURST=4).
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns after that.
module tb_fifo_push_arb;
    logic        clk;
    logic        reset_n;
    logic [15:0] dat [4];
    int          total;
    int          bad;
`ifdef FIFO_PUSH_ARB_STATS_EN
    logic        stall_clr;
    logic [15:0] stall_cnt;
`endif

    fifo_push_arb_if #(.NUM_REQ(4), .DATA_W(16)) bus ();

    fifo_push_arb #(.NUM_REQ(4), .DATA_W(16), .MAX_BURST(4)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef FIFO_PUSH_ARB_STATS_EN
        ,
        .stall_clr_i (stall_clr),
        .stall_cnt_o (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb bus.req_data_i = {dat[3], dat[2], dat[1], dat[0]};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int k = 0; k < 4; k++) dat[k] = 16'hC0D0 + 16'(k);
        reset_n          = 1'b0;
        bus.req_i        = 4'b1111;
        bus.req_last_i   = 4'b0000;
        bus.fifo_full_i  = 1'b0;
`ifdef FIFO_PUSH_ARB_STATS_EN
        stall_clr = 1'b0;
`endif

        // reset held with all requests high
        repeat (2) cyc();
        chk("rst_gnt",   bus.gnt_o,   0);
        chk("rst_push",  bus.push_o,  0);
        chk("rst_data",  bus.push_data_o, 0);
        chk("rst_owner", bus.owner_o, 0);
        chk("rst_busy",  bus.busy_o,  0);
        reset_n = 1'b1;
        #1;
        chk("arb_wait_gnt", bus.gnt_o, 0);
        cyc();

        // all four requesting, no last: 4 beats each, one idle cycle, order 0,1,2,3,0
        for (int g = 0; g < 5; g++) begin
            for (int b = 0; b < 4; b++) begin
                chk($sformatf("rr_g%0d_b%0d_gnt", g, b),   bus.gnt_o,   32'(4'b0001 << (g % 4)));
                chk($sformatf("rr_g%0d_b%0d_push", g, b),  bus.push_o,  1);
                chk($sformatf("rr_g%0d_b%0d_data", g, b),  bus.push_data_o, 16'hC0D0 + 16'(g % 4));
                chk($sformatf("rr_g%0d_b%0d_owner", g, b), bus.owner_o, g % 4);
                cyc();
            end
            chk($sformatf("rr_g%0d_idle_gnt", g),  bus.gnt_o,  0);
            chk($sformatf("rr_g%0d_idle_busy", g), bus.busy_o, 0);
            chk($sformatf("rr_g%0d_idle_push", g), bus.push_o, 0);
            if (g < 4) cyc();
        end

        // requester 2 alone, three beats with last on the third
        bus.req_i = 4'b0100;
        dat[2]    = 16'hA001;
        #1;
        chk("r2_wait_gnt", bus.gnt_o, 0);
        cyc();
        chk("r2_gnt",  bus.gnt_o, 4'b0100);
        chk("r2_busy", bus.busy_o, 1);
        chk("r2_p1",   bus.push_o, 1);
        chk("r2_d1",   bus.push_data_o, 16'hA001);
        cyc();
        dat[2] = 16'hA002;
        #1;
        chk("r2_p2", bus.push_o, 1);
        chk("r2_d2", bus.push_data_o, 16'hA002);
        cyc();
        dat[2]         = 16'hA003;
        bus.req_last_i = 4'b0100;
        #1;
        chk("r2_p3", bus.push_o, 1);
        chk("r2_d3", bus.push_data_o, 16'hA003);
        cyc();
        chk("r2_rel_gnt",   bus.gnt_o, 0);
        chk("r2_rel_busy",  bus.busy_o, 0);
        chk("r2_rel_owner", bus.owner_o, 2);
        chk("r2_rel_push",  bus.push_o, 0);
        bus.req_i      = 4'b0000;
        bus.req_last_i = 4'b0000;

        // requester 1 with 3 full cycles after its first beat; last while full is ignored
        bus.req_i = 4'b0010;
        #1;
        cyc();
        chk("bp_gnt",   bus.gnt_o, 4'b0010);
        chk("bp_push0", bus.push_o, 1);
        cyc();
        bus.fifo_full_i = 1'b1;
        #1;
        chk("bp_full1_push", bus.push_o, 0);
        chk("bp_full1_gnt",  bus.gnt_o, 4'b0010);
        cyc();
        bus.req_last_i = 4'b0010;
        #1;
        chk("bp_full2_push", bus.push_o, 0);
        chk("bp_full2_gnt",  bus.gnt_o, 4'b0010);
        cyc();
        bus.req_last_i = 4'b0000;
        #1;
        chk("bp_full3_push", bus.push_o, 0);
        chk("bp_full3_busy", bus.busy_o, 1);
        cyc();
        bus.fifo_full_i = 1'b0;
        #1;
        for (int b = 0; b < 3; b++) begin
            chk($sformatf("bp_after_b%0d_push", b), bus.push_o, 1);
            chk($sformatf("bp_after_b%0d_gnt", b),  bus.gnt_o, 4'b0010);
            cyc();
        end
        chk("bp_rel_gnt",  bus.gnt_o, 0);
        chk("bp_rel_busy", bus.busy_o, 0);
        bus.req_i = 4'b0000;

        // requester 0 abandons after one beat while requester 3 waits
        bus.req_i = 4'b0001;
        #1;
        cyc();
        chk("ab_gnt0",  bus.gnt_o, 4'b0001);
        chk("ab_push0", bus.push_o, 1);
        bus.req_i = 4'b1001;
        #1;
        chk("ab_nonowner_gnt",  bus.gnt_o, 4'b0001);
        chk("ab_nonowner_data", bus.push_data_o, 16'hC0D0);
        cyc();
        bus.req_i = 4'b1000;
        #1;
        chk("ab_drop_push", bus.push_o, 0);
        chk("ab_drop_gnt",  bus.gnt_o, 4'b0001);
        cyc();
        chk("ab_idle_gnt",   bus.gnt_o, 0);
        chk("ab_idle_owner", bus.owner_o, 0);
        cyc();
        chk("ab_gnt3",   bus.gnt_o, 4'b1000);
        chk("ab_owner3", bus.owner_o, 3);
        chk("ab_push3",  bus.push_o, 1);

        // asynchronous reset mid-burst; afterwards 0 beats 3
        cyc();
        chk("mr_beat2_push", bus.push_o, 1);
        bus.req_i = 4'b1001;
        reset_n   = 1'b0;
        #1;
        chk("mr_gnt",   bus.gnt_o, 0);
        chk("mr_push",  bus.push_o, 0);
        chk("mr_busy",  bus.busy_o, 0);
        chk("mr_owner", bus.owner_o, 0);
        cyc();
        reset_n = 1'b1;
        #1;
        chk("mr_idle_gnt", bus.gnt_o, 0);
        cyc();
        chk("mr_gnt0",  bus.gnt_o, 4'b0001);
        chk("mr_owner0", bus.owner_o, 0);

`ifdef FIFO_PUSH_ARB_STATS_EN
        stall_clr       = 1'b1;
        bus.fifo_full_i = 1'b1;
        cyc();
        stall_clr = 1'b0;
        #1;
        chk("st_clr0", stall_cnt, 0);
        repeat (5) cyc();
        chk("st_cnt5", stall_cnt, 5);
        chk("st_gnt_held", bus.gnt_o, 4'b0001);
        stall_clr = 1'b1;
        cyc();
        stall_clr = 1'b0;
        chk("st_clr", stall_cnt, 0);
        bus.fifo_full_i = 1'b0;
`endif

        bus.req_i = 4'b0000;
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
